// File: rtl/ras_ctrl.sv
// Fetch-side return-address-stack controller: pre-decodes RV32 call/return
// hints, issues push/pop to the stack, and drains it on a backend flush.
module ras_ctrl #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    // Fetch interface
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_instr,

    // Backend
    input  logic                 flush,

    // Stack interface
    output logic                 ras_push,
    output logic                 ras_pop,
    output logic [XLEN-1:0]      ras_push_data,
    input  logic [XLEN-1:0]      ras_pop_data,
    input  logic                 ras_full,
    input  logic                 ras_empty,

    // Prediction to the fetch PC mux
    output logic                 pred_valid,
    output logic                 pred_hit,
    output logic [XLEN-1:0]      pred_target,

    // Event counters
    output logic [CNT_WIDTH-1:0] overflow_cnt,
    output logic [CNT_WIDTH-1:0] underflow_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_CORO_PUSH,
        ST_DRAIN
    } state_e;

    typedef enum logic [1:0] {
        HINT_NONE,
        HINT_CALL,
        HINT_RET,
        HINT_CORO
    } hint_e;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    state_e                state_q, state_d;
    logic [XLEN-1:0]       link_q, link_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_hit_q, pred_hit_d;
    logic [XLEN-1:0]       pred_target_q, pred_target_d;
    logic [CNT_WIDTH-1:0]  overflow_cnt_q, overflow_cnt_d;
    logic [CNT_WIDTH-1:0]  underflow_cnt_q, underflow_cnt_d;

    // ------------------------------------------------------------------
    // Pre-decode
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            rd_link;
    logic            rs1_link;
    hint_e           instr_kind;
    logic [XLEN-1:0] pc_plus4;

    // The immediate field plays no part in call/return classification.
    logic            unused_imm_bits;

    assign opcode          = in_instr[6:0];
    assign rd              = in_instr[11:7];
    assign funct3          = in_instr[14:12];
    assign rs1             = in_instr[19:15];
    assign unused_imm_bits = ^in_instr[31:20];
    assign pc_plus4        = in_pc + XLEN'(4);

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    assign rd_link  = is_link(rd);
    assign rs1_link = is_link(rs1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        instr_kind = HINT_NONE;
        if (opcode == OPC_JAL) begin
            if (rd_link) instr_kind = HINT_CALL;
        end else if (opcode == OPC_JALR && funct3 == 3'b000) begin
            unique case ({rd_link, rs1_link})
                2'b10:   instr_kind = HINT_CALL;
                2'b01:   instr_kind = HINT_RET;
                2'b11:   instr_kind = (rd == rs1) ? HINT_CALL : HINT_CORO;
                default: instr_kind = HINT_NONE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, stack requests and prediction
    // ------------------------------------------------------------------
    logic overflow_evt;
    logic underflow_evt;

    always_comb begin
        state_d       = state_q;
        link_d        = link_q;
        pred_valid_d  = 1'b0;
        pred_hit_d    = 1'b0;
        pred_target_d = '0;
        in_ready      = 1'b0;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        ras_push_data = pc_plus4;
        overflow_evt  = 1'b0;
        underflow_evt = 1'b0;

        // Reset masks all stack traffic; the register block restores RUN.
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    in_ready = !flush;
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end else if (in_valid) begin
                        unique case (instr_kind)
                            HINT_CALL: begin
                                ras_push     = 1'b1;
                                overflow_evt = ras_full;
                            end
                            HINT_RET: begin
                                pred_valid_d = 1'b1;
                                if (!ras_empty) begin
                                    ras_pop       = 1'b1;
                                    pred_hit_d    = 1'b1;
                                    pred_target_d = ras_pop_data;
                                end else begin
                                    underflow_evt = 1'b1;
                                end
                            end
                            HINT_CORO: begin
                                pred_valid_d = 1'b1;
                                if (!ras_empty) begin
                                    // Pop now, push the new link next cycle so
                                    // the two never share a cycle.
                                    ras_pop       = 1'b1;
                                    pred_hit_d    = 1'b1;
                                    pred_target_d = ras_pop_data;
                                    link_d        = pc_plus4;
                                    state_d       = ST_CORO_PUSH;
                                end else begin
                                    ras_push      = 1'b1;
                                    underflow_evt = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_CORO_PUSH: begin
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end else begin
                        ras_push      = 1'b1;
                        ras_push_data = link_q;
                        overflow_evt  = ras_full;
                        state_d       = ST_RUN;
                    end
                end

                ST_DRAIN: begin
                    ras_pop = !ras_empty;
                    if (ras_empty && !flush) state_d = ST_RUN;
                end

                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        overflow_cnt_d  = overflow_cnt_q;
        underflow_cnt_d = underflow_cnt_q;
        if (overflow_evt && (overflow_cnt_q != '1))
            overflow_cnt_d = overflow_cnt_q + CNT_WIDTH'(1);
        if (underflow_evt && (underflow_cnt_q != '1))
            underflow_cnt_d = underflow_cnt_q + CNT_WIDTH'(1);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            link_q          <= '0;
            pred_valid_q    <= 1'b0;
            pred_hit_q      <= 1'b0;
            pred_target_q   <= '0;
            overflow_cnt_q  <= '0;
            underflow_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            link_q          <= link_d;
            pred_valid_q    <= pred_valid_d;
            pred_hit_q      <= pred_hit_d;
            pred_target_q   <= pred_target_d;
            overflow_cnt_q  <= overflow_cnt_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign pred_valid    = pred_valid_q;
    assign pred_hit      = pred_hit_q;
    assign pred_target   = pred_target_q;
    assign overflow_cnt  = overflow_cnt_q;
    assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl against a 7-entry behavioural stack, plus a
// second instance with 2-bit counters for saturation.
module tb_ras_ctrl;

    localparam logic [31:0] JAL_RA    = 32'h008000EF; // jal ra, 8
    localparam logic [31:0] JAL_X0    = 32'h0080006F; // j 8 (no link)
    localparam logic [31:0] RET_RA    = 32'h00008067; // jalr x0, 0(x1)
    localparam logic [31:0] RET_T0    = 32'h00028067; // jalr x0, 0(x5)
    localparam logic [31:0] CALL_RARA = 32'h000080E7; // jalr x1, 0(x1)
    localparam logic [31:0] CORO      = 32'h000280E7; // jalr x1, 0(x5)
    localparam logic [31:0] NOP       = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid2;
    logic [31:0] in_pc, in_instr;
    logic        flush;

    logic        in_ready, ras_push, ras_pop;
    logic [31:0] ras_push_data, ras_pop_data;
    logic        ras_full, ras_empty;
    logic        pred_valid, pred_hit;
    logic [31:0] pred_target;
    logic [15:0] overflow_cnt, underflow_cnt;

    logic        in_ready2, ras_push2, ras_pop2, pred_valid2, pred_hit2;
    logic [31:0] ras_push_data2, pred_target2;
    logic [1:0]  overflow_cnt2, underflow_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ras_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_push_data(ras_push_data),
        .ras_pop_data(ras_pop_data), .ras_full(ras_full), .ras_empty(ras_empty),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_target(pred_target),
        .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
    );

    ras_ctrl #(.XLEN(32), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_pc(in_pc), .in_instr(in_instr),
        .flush(1'b0),
        .ras_push(ras_push2), .ras_pop(ras_pop2), .ras_push_data(ras_push_data2),
        .ras_pop_data(32'h0), .ras_full(1'b0), .ras_empty(1'b1),
        .pred_valid(pred_valid2), .pred_hit(pred_hit2), .pred_target(pred_target2),
        .overflow_cnt(overflow_cnt2), .underflow_cnt(underflow_cnt2)
    );

    // Behavioural 7-entry stack; survives rst so a reset mid-drain is visible.
    logic        stk_clr;
    logic [31:0] stk [0:7];
    logic [2:0]  sp;

    assign ras_empty    = (sp == 3'd0);
    assign ras_full     = (sp == 3'd7);
    assign ras_pop_data = ras_empty ? 32'h0 : stk[sp - 3'd1];

    always @(posedge clk) begin
        if (stk_clr) begin
            sp <= 3'd0;
        end else if (ras_push && !ras_full) begin
            stk[sp] <= ras_push_data;
            sp      <= sp + 3'd1;
        end else if (ras_pop && !ras_empty) begin
            sp <= sp - 3'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stalls, pops, pushes, exp_unf;

        rst = 1'b1; stk_clr = 1'b1; flush = 1'b0; in_valid2 = 1'b0;
        drive(1'b1, 32'h40, JAL_RA);
        repeat (2) @(posedge clk);
        #1;
        check("rst_push",   32'(ras_push), 32'd0);
        check("rst_pop",    32'(ras_pop), 32'd0);
        check("rst_pv",     32'(pred_valid), 32'd0);
        check("rst_hit",    32'(pred_hit), 32'd0);
        check("rst_target", pred_target, 32'h0);
        check("rst_ovf",    32'(overflow_cnt), 32'd0);
        check("rst_unf",    32'(underflow_cnt), 32'd0);
        rst = 1'b0; stk_clr = 1'b0; in_valid = 1'b0;
        #1;
        check("run_ready", 32'(in_ready), 32'd1);

        // Return on an empty stack
        drive(1'b1, 32'h80, RET_RA); #1;
        check("eret_pop",  32'(ras_pop), 32'd0);
        check("eret_push", 32'(ras_push), 32'd0);
        tick;
        check("eret_pv",  32'(pred_valid), 32'd1);
        check("eret_hit", 32'(pred_hit), 32'd0);
        check("eret_tgt", pred_target, 32'h0);
        check("eret_unf", 32'(underflow_cnt), 32'd1);
        in_valid = 1'b0;
        tick;
        check("eret_pv_pulse", 32'(pred_valid), 32'd0);

        // Call / return
        drive(1'b1, 32'h100, JAL_RA); #1;
        check("call_push", 32'(ras_push), 32'd1);
        check("call_data", ras_push_data, 32'h104);
        check("call_pop",  32'(ras_pop), 32'd0);
        tick;
        check("call_pv", 32'(pred_valid), 32'd0);
        drive(1'b1, 32'h104, RET_RA); #1;
        check("ret_pop",  32'(ras_pop), 32'd1);
        check("ret_push", 32'(ras_push), 32'd0);
        tick;
        check("ret_pv",  32'(pred_valid), 32'd1);
        check("ret_hit", 32'(pred_hit), 32'd1);
        check("ret_tgt", pred_target, 32'h104);

        // Non-hint instructions
        drive(1'b1, 32'h110, NOP); #1;
        check("nop_push", 32'(ras_push), 32'd0);
        check("nop_pop",  32'(ras_pop), 32'd0);
        tick;
        check("nop_pv", 32'(pred_valid), 32'd0);
        drive(1'b1, 32'h114, JAL_X0); #1;
        check("j_push", 32'(ras_push), 32'd0);
        tick;

        // jalr x1,0(x1) is a call; jalr x0,0(x5) is a return
        drive(1'b1, 32'h180, CALL_RARA); #1;
        check("jalr_call_push", 32'(ras_push), 32'd1);
        check("jalr_call_data", ras_push_data, 32'h184);
        tick;
        drive(1'b1, 32'h190, RET_T0); #1;
        check("t0_ret_pop", 32'(ras_pop), 32'd1);
        tick;
        check("t0_ret_tgt", pred_target, 32'h184);

        // Overflow: 7 entries fit, the 8th call is dropped
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000 + 32'(i) * 32'h10, JAL_RA); #1;
            check("ovf_call_push", 32'(ras_push), 32'd1);
            tick;
            if (i == 6) check("ovf_before", 32'(overflow_cnt), 32'd0);
        end
        check("ovf_cnt", 32'(overflow_cnt), 32'd1);
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, 32'h2000, RET_RA); #1;
            check("lifo_pop", 32'(ras_pop), 32'd1);
            tick;
            check("lifo_hit", 32'(pred_hit), 32'd1);
            check("lifo_tgt", pred_target, 32'h1004 + 32'(i) * 32'h10);
        end

        // Coroutine swap with a populated stack
        drive(1'b1, 32'h200, JAL_RA); tick;
        drive(1'b1, 32'h300, CORO); #1;
        check("coro_pop",   32'(ras_pop), 32'd1);
        check("coro_push",  32'(ras_push), 32'd0);
        check("coro_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0; #1;
        check("coro_pv",        32'(pred_valid), 32'd1);
        check("coro_hit",       32'(pred_hit), 32'd1);
        check("coro_tgt",       pred_target, 32'h204);
        check("cpush_ready",    32'(in_ready), 32'd0);
        check("cpush_push",     32'(ras_push), 32'd1);
        check("cpush_data",     ras_push_data, 32'h304);
        check("cpush_pop",      32'(ras_pop), 32'd0);
        tick;
        check("cpush_back_run", 32'(in_ready), 32'd1);
        check("cpush_pv",       32'(pred_valid), 32'd0);
        drive(1'b1, 32'h310, RET_RA); tick;
        check("coro_link_tgt",  pred_target, 32'h304);

        // Coroutine swap on an empty stack
        drive(1'b1, 32'h400, CORO); #1;
        check("ecoro_push", 32'(ras_push), 32'd1);
        check("ecoro_data", ras_push_data, 32'h404);
        check("ecoro_pop",  32'(ras_pop), 32'd0);
        tick;
        check("ecoro_pv",    32'(pred_valid), 32'd1);
        check("ecoro_hit",   32'(pred_hit), 32'd0);
        check("ecoro_tgt",   pred_target, 32'h0);
        check("ecoro_unf",   32'(underflow_cnt), 32'd2);
        check("ecoro_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h410, RET_RA); tick;
        check("ecoro_ret_tgt", pred_target, 32'h404);

        // Flush with three entries: three pops, four stall cycles in DRAIN
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(i) * 32'h10, JAL_RA); tick;
        end
        flush = 1'b1; drive(1'b1, 32'h530, JAL_RA); #1;
        check("flush_ready", 32'(in_ready), 32'd0);
        check("flush_push",  32'(ras_push), 32'd0);
        tick;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_pv", 32'(pred_valid), 32'd0);
        stalls = 0; pops = 0; pushes = 0;
        for (int k = 0; k < 12 && !in_ready; k++) begin
            stalls++;
            if (ras_pop)  pops++;
            if (ras_push) pushes++;
            tick;
        end
        check("drain_done",   32'(in_ready), 32'd1);
        check("drain_stalls", 32'(stalls), 32'd4);
        check("drain_pops",   32'(pops), 32'd3);
        check("drain_pushes", 32'(pushes), 32'd0);
        drive(1'b1, 32'h540, RET_RA); tick;
        check("drained_hit", 32'(pred_hit), 32'd0);
        check("drained_unf", 32'(underflow_cnt), 32'd3);

        // Flush during CORO_PUSH cancels the pending push
        drive(1'b1, 32'h600, JAL_RA); tick;
        drive(1'b1, 32'h700, CORO); tick;
        check("cflush_tgt", pred_target, 32'h604);
        flush = 1'b1; in_valid = 1'b0; #1;
        check("cflush_push", 32'(ras_push), 32'd0);
        tick;
        flush = 1'b0; #1;
        check("cflush_pv",    32'(pred_valid), 32'd0);
        check("cflush_ready", 32'(in_ready), 32'd0);
        check("cflush_pop",   32'(ras_pop), 32'd0);
        tick;
        check("cflush_run", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h710, RET_RA); tick;
        check("cflush_nohit", 32'(pred_hit), 32'd0);
        in_valid = 1'b0;

        // Reset in the middle of DRAIN
        drive(1'b1, 32'h800, JAL_RA); tick;
        drive(1'b1, 32'h810, JAL_RA); tick;
        in_valid = 1'b0; flush = 1'b1; tick;
        flush = 1'b0; #1;
        check("rdrain_pop",   32'(ras_pop), 32'd1);
        check("rdrain_ready", 32'(in_ready), 32'd0);
        tick;
        rst = 1'b1; #1;
        check("rdrain_rst_pop",  32'(ras_pop), 32'd0);
        check("rdrain_rst_push", 32'(ras_push), 32'd0);
        tick;
        rst = 1'b0; #1;
        check("rdrain_run", 32'(in_ready), 32'd1);
        check("rdrain_ovf", 32'(overflow_cnt), 32'd0);
        check("rdrain_unf", 32'(underflow_cnt), 32'd0);
        drive(1'b1, 32'h820, RET_RA); #1;
        check("rdrain_ret_pop", 32'(ras_pop), 32'd1);
        tick;
        check("rdrain_ret_tgt", pred_target, 32'h804);
        in_valid = 1'b0;

        // Two-bit counter saturation on the second instance
        in_pc = 32'h900; in_instr = RET_RA; in_valid2 = 1'b1; #1;
        check("sat_pop",   32'(ras_pop2), 32'd0);
        check("sat_push",  32'(ras_push2), 32'd0);
        check("sat_ready", 32'(in_ready2), 32'd1);
        check("sat_pdata", ras_push_data2, 32'h904);
        for (int n = 1; n <= 5; n++) begin
            tick;
            exp_unf = (n < 3) ? n : 3;
            check("sat_unf", 32'(underflow_cnt2), 32'(exp_unf));
            check("sat_pv",  32'(pred_valid2), 32'd1);
            check("sat_hit", 32'(pred_hit2), 32'd0);
            check("sat_tgt", pred_target2, 32'h0);
        end
        in_valid2 = 1'b0;
        check("sat_ovf", 32'(overflow_cnt2), 32'd0);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
